// File: rtl/opc_memsys.sv
// rtl/opc_memsys.sv - wait-stated CPU memory with interrupt generator, halt latch and cycle counter
module opc_memsys #(
  parameter int          AW          = 16,
  parameter int          DW          = 16,
  parameter int          WAIT_STATES = 1,
  parameter int          INT_MODE    = 2,
  parameter int          INT_PERIOD  = 64,
  parameter int          INT_THRESH  = 32,
  parameter int          INT_WIDTH   = 4,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] address,
  input  logic [DW-1:0] din,
  input  logic          rnw,
  input  logic          vpa,
  input  logic          vda,
  input  logic          halt,
  input  logic          int_en,
  output logic [DW-1:0] dout,
  output logic          clken,
  output logic          int_b,
  output logic          done,
  output logic [31:0]   cycle_count
);

  // A zero seed would lock the LFSR, so it falls back to the default seed.
  localparam logic [15:0] SEED        = (LFSR_SEED == 16'h0) ? 16'hACE1 : LFSR_SEED;
  localparam logic [3:0]  WCNT_INIT   = 4'(WAIT_STATES - 1);
  localparam logic [15:0] PERIOD_LAST = 16'(INT_PERIOD - 1);
  localparam logic [15:0] WIDTH_LAST  = 16'(INT_WIDTH - 1);
  localparam logic [8:0]  THRESH      = 9'(INT_THRESH);

  typedef enum logic {ST_IDLE, ST_WAIT} state_t;

  logic [DW-1:0] mem [0:(1<<AW)-1];

  state_t      state, state_nxt;
  logic [3:0]  wcnt, wcnt_nxt;
  logic [15:0] lfsr;
  logic [15:0] pcnt;
  logic [15:0] icnt;
  logic        mreq;
  logic        we;
  logic        wrap;
  logic        fire;
  logic        set_done;

  assign mreq     = vpa | vda;
  // Writes land only in the completing cycle of an access, never once halted or in reset.
  assign we       = (state == ST_WAIT) && (wcnt == 4'd0) && mreq && !rnw && !done && !reset;
  assign wrap     = (pcnt == PERIOD_LAST);
  assign fire     = int_en && wrap &&
                    ((INT_MODE == 1) || ((INT_MODE == 2) && ({1'b0, lfsr[7:0]} < THRESH)));
  assign set_done = halt && clken && !done && !reset;

  // Access FSM next-state and clock-enable decode.
  always_comb begin
    state_nxt = state;
    wcnt_nxt  = wcnt;
    clken     = 1'b1;
    case (state)
      ST_IDLE: begin
        clken = !mreq;
        if (mreq) begin
          state_nxt = ST_WAIT;
          wcnt_nxt  = WCNT_INIT;
        end
      end
      ST_WAIT: begin
        clken = (wcnt == 4'd0);
        if (wcnt != 4'd0) begin
          wcnt_nxt = wcnt - 4'd1;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
    // A halted CPU is frozen: no clock enable and no new accesses.
    if (done) begin
      clken     = 1'b0;
      state_nxt = ST_IDLE;
      wcnt_nxt  = 4'd0;
    end
    if (reset) begin
      clken = 1'b1;
    end
  end

  // Access FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      wcnt  <= 4'd0;
    end else begin
      state <= state_nxt;
      wcnt  <= wcnt_nxt;
    end
  end

  // Memory array write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[address] <= din;
    end
  end

  // Registered read port: one-cycle latency, old data on a same-edge write.
  always_ff @(posedge clk) begin
    if (reset) begin
      dout <= '0;
    end else begin
      dout <= mem[address];
    end
  end

  // Free-running Galois LFSR and interrupt decision period counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr <= SEED;
      pcnt <= 16'd0;
    end else begin
      lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
      pcnt <= wrap ? 16'd0 : pcnt + 16'd1;
    end
  end

  // Interrupt pulse shaper: fixed-width low pulse, fires ignored while active.
  always_ff @(posedge clk) begin
    if (reset) begin
      int_b <= 1'b1;
      icnt  <= 16'd0;
    end else if (!int_en || done || set_done) begin
      int_b <= 1'b1;
    end else if (!int_b) begin
      if (icnt == 16'd0) begin
        int_b <= 1'b1;
      end else begin
        icnt <= icnt - 16'd1;
      end
    end else if (fire) begin
      int_b <= 1'b0;
      icnt  <= WIDTH_LAST;
    end
  end

  // Sticky halt flag and cycle counter that freezes once halted.
  always_ff @(posedge clk) begin
    if (reset) begin
      done        <= 1'b0;
      cycle_count <= 32'd0;
    end else begin
      if (set_done) begin
        done <= 1'b1;
      end
      if (!done) begin
        cycle_count <= cycle_count + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_opc_memsys.sv
// tb/tb_opc_memsys.sv - randomized bench for opc_memsys against a cycle-numbered reference model
module tb_opc_memsys;

  localparam int AW  = 8;
  localparam int DW  = 16;
  localparam int WS  = 3;
  localparam int PER = 10;
  localparam int THR = 100;
  localparam int WID = 4;
  localparam int N   = 4000;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [AW-1:0] address = '0;
  logic [DW-1:0] din = '0;
  logic          rnw = 1'b1;
  logic          vpa = 1'b0;
  logic          vda = 1'b0;
  logic          halt = 1'b0;
  logic          int_en = 1'b0;
  logic [DW-1:0] dout;
  logic          clken;
  logic          int_b;
  logic          done;
  logic [31:0]   cycle_count;

  always #5 clk = ~clk;

  opc_memsys #(
    .AW(AW), .DW(DW), .WAIT_STATES(WS), .INT_MODE(2), .INT_PERIOD(PER),
    .INT_THRESH(THR), .INT_WIDTH(WID), .LFSR_SEED(16'h0000)
  ) dut (
    .clk(clk), .reset(reset), .address(address), .din(din), .rnw(rnw),
    .vpa(vpa), .vda(vda), .halt(halt), .int_en(int_en), .dout(dout),
    .clken(clken), .int_b(int_b), .done(done), .cycle_count(cycle_count)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    logic lsb;
    lsb = s[0];
    s   = s >> 1;
    if (lsb) s = s ^ 16'hB400;
    return s;
  endfunction

  // Reference model: accesses are tracked by their start cycle number.
  logic [DW-1:0] m_mem [256];
  bit            m_known [256];
  bit            m_valid = 0;
  bit            m_busy, m_done, m_ib, m_dout_known;
  int            m_start, m_tcyc, m_low_end;
  logic [31:0]   m_cc;
  logic [15:0]   m_lfsr;
  logic [DW-1:0] m_dout;

  initial begin
    bit          bus_free;
    bit          e_clken;
    bit          mreq_v;
    bit          completing;
    bit          fire;
    bit          new_done;
    logic [31:0] r;

    for (int i = 0; i < 256; i++) m_known[i] = 0;
    bus_free = 1;
    for (int c = 0; c < N; c++) begin
      @(negedge clk);
      reset = (c < 3) || ($urandom_range(0, 149) == 0);
      if (bus_free) begin
        r       = $urandom;
        vpa     = r[0];
        vda     = r[1];
        rnw     = r[2];
        address = r[3] ? r[11:4] : {4'h0, r[15:12]};
        din     = r[31:16];
      end
      halt   = ($urandom_range(0, 199) == 0);
      int_en = ($urandom_range(0, 99) >= 4);
      #1;
      mreq_v  = vpa | vda;
      e_clken = reset ? 1'b1 : m_done ? 1'b0 : m_busy ? (m_tcyc == m_start + WS) : !mreq_v;
      if (reset || m_valid) chk("clken", {31'b0, clken}, {31'b0, e_clken});
      if (m_valid) begin
        chk("int_b", {31'b0, int_b}, {31'b0, m_ib});
        chk("done", {31'b0, done}, {31'b0, m_done});
        chk("cycle_count", cycle_count, m_cc);
        if (m_dout_known) chk("dout", {16'b0, dout}, {16'b0, m_dout});
      end
      @(posedge clk);
      if (reset) begin
        m_valid      = 1;
        m_busy       = 0;
        m_done       = 0;
        m_cc         = 32'd0;
        m_lfsr       = 16'hACE1;
        m_tcyc       = 0;
        m_ib         = 1;
        m_low_end    = 0;
        m_dout       = '0;
        m_dout_known = 1;
      end else if (m_valid) begin
        completing   = m_busy && (m_tcyc == m_start + WS);
        m_dout       = m_mem[address];
        m_dout_known = m_known[address];
        if (completing && mreq_v && !rnw && !m_done) begin
          m_mem[address]   = din;
          m_known[address] = 1;
        end
        if (completing) m_busy = 0;
        else if (!m_busy && mreq_v && !m_done) begin
          m_busy  = 1;
          m_start = m_tcyc;
        end
        fire     = int_en && ((m_tcyc % PER) == PER - 1) && (int'(m_lfsr[7:0]) < THR);
        new_done = m_done || (halt && e_clken);
        if (new_done || !int_en) m_ib = 1;
        else if (!m_ib) begin
          if (m_tcyc + 1 > m_low_end) m_ib = 1;
        end else if (fire) begin
          m_ib      = 0;
          m_low_end = m_tcyc + WID;
        end
        if (!m_done) m_cc = m_cc + 32'd1;
        m_done = new_done;
        m_lfsr = lfsr_step(m_lfsr);
        m_tcyc++;
      end
      bus_free = e_clken;
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/opc_memsys.md
OPC_MEMSYS -- requirements
Module: opc_memsys

Interface
REQ-001 Parameter AW, default 16, address width in bits; memory depth is 2**AW words.
REQ-002 Parameter DW, default 16, data word width in bits.
REQ-003 Parameter WAIT_STATES, default 1, legal range 1..15, stall cycles inserted per access.
REQ-004 Parameter INT_MODE, default 2; 0 = no interrupts, 1 = periodic, 2 = pseudo-random.
REQ-005 Parameter INT_PERIOD, default 64, range 2..65535, cycles between interrupt decision points.
REQ-006 Parameter INT_THRESH, default 32, range 0..256; mode-2 fire threshold.
REQ-007 Parameter INT_WIDTH, default 4, range 1..INT_PERIOD-1, int_b low-pulse length in cycles.
REQ-008 Parameter LFSR_SEED, default 16'hACE1; a value of 0 SHALL be replaced by 16'hACE1.
REQ-009 clk  in  1  single system clock; all state updates on its rising edge.
REQ-010 reset  in  1  synchronous, active-high reset.
REQ-011 address  in  AW  CPU address.
REQ-012 din  in  DW  CPU write data.
REQ-013 rnw  in  1  1 = read, 0 = write.
REQ-014 vpa, vda  in  1 each  valid program / data address; mreq = vpa | vda.
REQ-015 halt  in  1  CPU halt-instruction-in-execute indication.
REQ-016 int_en  in  1  interrupt generator enable.
REQ-017 dout  out  DW  registered read data to CPU.
REQ-018 clken  out  1  CPU clock enable (combinational from state and mreq).
REQ-019 int_b  out  1  active-low interrupt request, registered.
REQ-020 done  out  1  sticky halt flag, registered.
REQ-021 cycle_count  out  32  clk cycles since reset, registered.

Function
REQ-022 Access FSM SHALL have states IDLE and WAIT plus a 4-bit wait counter wcnt.
REQ-023 In IDLE with mreq=1, clken SHALL be 0 and the FSM SHALL go to WAIT with wcnt=WAIT_STATES-1.
REQ-024 In IDLE with mreq=0, clken SHALL be 1 and the FSM SHALL stay in IDLE.
REQ-025 In WAIT, clken SHALL equal (wcnt==0); wcnt SHALL decrement while nonzero; at wcnt==0 the FSM SHALL return to IDLE.
REQ-026 Every access SHALL therefore take exactly WAIT_STATES+1 cycles, with clken high only in the final (completing) cycle.
REQ-027 Back-to-back accesses SHALL each be stalled again, with no lost or merged requests.
REQ-028 dout SHALL load mem[address] on every rising edge, giving one-cycle read latency.
REQ-029 A write SHALL occur only in the completing cycle (WAIT, wcnt==0, mreq=1, rnw=0): mem[address] <= din, exactly once per access.
REQ-030 A read of the same address in the cycle after a write SHALL return the new data.
REQ-031 The 16-bit Galois LFSR (taps 16,14,13,11) SHALL advance every cycle; a period counter SHALL count 0..INT_PERIOD-1 and wrap.
REQ-032 A fire event SHALL occur at counter wrap when mode 1 is selected, or when mode 2 is selected and lfsr[7:0] < INT_THRESH.
REQ-033 A fire event SHALL require int_en=1; int_b SHALL then be low for exactly INT_WIDTH cycles starting the next cycle.
REQ-034 A fire event during an active pulse SHALL be ignored.
REQ-035 int_en=0 SHALL abort an active pulse, with int_b=1 the next cycle.
REQ-036 INT_MODE=0 SHALL hold int_b=1 permanently.
REQ-037 When halt=1 and clken=1 in the same cycle, done SHALL be set the next cycle and remain set until reset.
REQ-038 While done=1: clken SHALL be 0, no writes SHALL occur, int_b SHALL be 1, and cycle_count SHALL freeze.
REQ-039 cycle_count SHALL increment by 1 per cycle while done=0 and wrap at 2**32.

Reset
REQ-040 While reset=1: FSM=IDLE, wcnt=0, clken=1, dout=0, int_b=1, done=0, cycle_count=0, period counter=0, LFSR=seed.
REQ-041 Reset asserted mid-access SHALL abandon the access with no write, and the FSM SHALL be in IDLE on the first cycle after release.
REQ-042 Memory contents SHALL NOT be affected by reset.

Verification
REQ-043 WAIT_STATES=1, write 16'h1234 to 16'h0010 then read 16'h0010 -> clken pattern 0,1,0,1; dout=16'h1234 one cycle after the read completes.
REQ-044 WAIT_STATES=3, continuous mreq for 3 accesses -> clken high on cycles 4, 8, 12 only; exactly 3 memory updates.
REQ-045 INT_MODE=1, INT_PERIOD=10, INT_WIDTH=4, int_en=1 -> int_b low for cycles 10-13, 20-23, ...; dropping int_en at cycle 11 -> int_b=1 at cycle 12.
REQ-046 INT_MODE=2, INT_THRESH=0 -> int_b never low; INT_THRESH=256 -> behaves identically to mode 1.
REQ-047 halt=1 during a completing cycle at cycle_count=100 -> done=1 the next cycle, cycle_count frozen at 101, clken=0, a later write attempt does not alter memory.
REQ-048 Reset pulsed during WAIT of a write -> target word unchanged; all outputs at REQ-040 values.
